// File: rtl/alu_pkg.sv
// Shared definitions for the alu_core datapath.
// Holds the opcode encoding and the default operand width.
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [3:0] {
    ADD   = 4'b0000,
    SUB   = 4'b0001,
    AND   = 4'b0010,
    OR    = 4'b0011,
    XOR   = 4'b0100,
    NOT   = 4'b0101,
    SHL   = 4'b0110,
    SHR   = 4'b0111,
    ROL   = 4'b1000,
    ROR   = 4'b1001,
    MUL   = 4'b1010,
    INC   = 4'b1011,
    DEC   = 4'b1100,
    EQ    = 4'b1101,
    LTU   = 4'b1110,
    PASSB = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/alu_ops.sv
// Combinational ALU function block: (a, b, select) -> result.
// All arithmetic is unsigned and wraps modulo 2^WIDTH.
module alu_ops
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_e          i_op,
  output logic [WIDTH-1:0] o_result
);

  logic [WIDTH-1:0] w_one;
  assign w_one = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    // NOTE: default first so every path assigns o_result and no latch is inferred.
    o_result = '0;
    case (i_op)
      ADD:   o_result = i_a + i_b;
      SUB:   o_result = i_a - i_b;
      AND:   o_result = i_a & i_b;
      OR:    o_result = i_a | i_b;
      XOR:   o_result = i_a ^ i_b;
      NOT:   o_result = ~i_a;
      SHL:   o_result = {i_a[WIDTH-2:0], 1'b0};
      SHR:   o_result = {1'b0, i_a[WIDTH-1:1]};
      ROL:   o_result = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
      ROR:   o_result = {i_a[0], i_a[WIDTH-1:1]};
      MUL:   o_result = i_a * i_b;
      INC:   o_result = i_a + w_one;
      DEC:   o_result = i_a - w_one;
      EQ:    o_result = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
      LTU:   o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      PASSB: o_result = i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// Registered ALU: operands and opcode sampled each edge, result one cycle later.
// The output is o_final because "final" is a reserved word in SystemVerilog.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  output logic [WIDTH-1:0] o_final
);

  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_final;

  alu_ops #(.WIDTH(WIDTH)) u_ops (
    .i_a      (a),
    .i_b      (b),
    .i_op     (alu_op_e'(select)),
    .o_result (w_result)
  );

  // rst is active-low; asserting it clears the result without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_final <= '0;
    end else begin
      // NOTE: non-blocking assignment for state so all flops update together at the edge.
      r_final <= w_result;
    end
  end

  assign o_final = r_final;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vectors, random stimulus against
// an arithmetic reference model, reset and between-edge behaviour.
`timescale 1ns/1ps
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] select;
  logic [7:0] dut_out;

  int n_total = 0;
  int n_bad   = 0;

  alu_core #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .select  (select),
    .o_final (dut_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%02h expected=%02h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model computed from the opcode table with plain integer arithmetic.
  function automatic logic [7:0] model(input int x, input int y, input int op);
    int r;
    case (op)
      0:  r = (x + y) % 256;
      1:  r = (x - y + 256) % 256;
      2:  r = x & y;
      3:  r = x | y;
      4:  r = x ^ y;
      5:  r = 255 - x;
      6:  r = (x * 2) % 256;
      7:  r = x / 2;
      8:  r = ((x * 2) % 256) + (x / 128);
      9:  r = (x / 2) + ((x % 2) * 128);
      10: r = (x * y) % 256;
      11: r = (x + 1) % 256;
      12: r = (x + 255) % 256;
      13: r = (x == y) ? 1 : 0;
      14: r = (x < y) ? 1 : 0;
      default: r = y;
    endcase
    return r[7:0];
  endfunction

  // Drive after the falling edge, sample 1 ns after the next rising edge.
  task automatic apply(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                       input logic [3:0] op, input logic [7:0] exp);
    @(negedge clk);
    a = xa; b = xb; select = op;
    @(posedge clk);
    #1;
    check(tag, dut_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb, held;
    logic [3:0] rop;

    // Reset held low with random operands: output must stay zero across edges.
    rst = 1'b0; a = 8'($urandom); b = 8'($urandom); select = 4'($urandom);
    #1;
    check("reset_initial", dut_out, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset_hold", dut_out, 8'h00);
      a = 8'($urandom); b = 8'($urandom);
    end
    @(negedge clk);
    a = 8'h3A; b = 8'h21; select = 4'b0000;
    rst = 1'b1;
    #1;
    check("reset_release_no_edge", dut_out, 8'h00);
    @(posedge clk); #1;
    check("reset_first_load", dut_out, model(8'h3A, 8'h21, 0));

    // Directed vectors with hand-computed results.
    apply("add_wrap", 8'h55, 8'hB5, 4'b0000, 8'h0A);
    apply("sub",      8'hDB, 8'hAA, 4'b0001, 8'h31);
    apply("and",      8'hDB, 8'hAA, 4'b0010, 8'h8A);
    apply("or",       8'hDB, 8'hAA, 4'b0011, 8'hFB);
    apply("xor",      8'hDB, 8'hAA, 4'b0100, 8'h71);
    apply("not",      8'h17, 8'h99, 4'b0101, 8'hE8);
    apply("shl",      8'h97, 8'hAA, 4'b0110, 8'h2E);
    apply("shr",      8'h97, 8'hAA, 4'b0111, 8'h4B);
    apply("rol",      8'h97, 8'hAA, 4'b1000, 8'h2F);
    apply("ror",      8'h97, 8'hAA, 4'b1001, 8'hCB);
    apply("mul",      8'h97, 8'hAA, 4'b1010, 8'h46);
    apply("inc_wrap", 8'hFF, 8'h00, 4'b1011, 8'h00);
    apply("dec_wrap", 8'h00, 8'h00, 4'b1100, 8'hFF);
    apply("eq_true",  8'h3C, 8'h3C, 4'b1101, 8'h01);
    apply("eq_false", 8'h3C, 8'h3D, 4'b1101, 8'h00);
    apply("ltu_true", 8'h01, 8'hFF, 4'b1110, 8'h01);
    apply("ltu_false",8'hFF, 8'h01, 4'b1110, 8'h00);
    apply("passb",    8'h12, 8'h5A, 4'b1111, 8'h5A);

    // Random stimulus across every opcode.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 4'($urandom_range(0, 15));
      if (i % 16 == 0) rb = ra;
      apply($sformatf("rand_op%0d", rop), ra, rb, rop, model(ra, rb, rop));
    end

    // Changing inputs between edges must not disturb the held result.
    apply("mid_setup", 8'h40, 8'h02, 4'b0000, 8'h42);
    held = 8'h42;
    #2;
    select = 4'b0001; a = 8'h10; b = 8'h01;
    #1;
    check("mid_change_hold", dut_out, held);
    @(negedge clk); #1;
    check("mid_change_hold_neg", dut_out, held);
    @(posedge clk); #1;
    check("mid_change_next_edge", dut_out, 8'h0F);

    // Async reset pulse between edges clears immediately.
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_clear", dut_out, 8'h00);
    @(posedge clk); #1;
    check("async_reset_hold_edge", dut_out, 8'h00);
    @(negedge clk);
    rst = 1'b1; a = 8'h80; b = 8'h00; select = 4'b1000;
    @(posedge clk); #1;
    check("after_async_reset_load", dut_out, 8'h01);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered 8-bit arithmetic/logic unit. Two operands and a 4-bit opcode are sampled each clock; the result is registered on the following rising edge.
- Leaf datapath block for small processor or datapath experiments. No handshake: every cycle computes a new result.

Parameters:
- WIDTH, 8, operand and result width in bits. All examples in this spec use 8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- select  input  4  opcode
- final  output  WIDTH  registered result

Behaviour:
- Reset:
  - rst low forces final = 0 immediately, independent of clk.
  - final stays 0 while rst is low.
  - The first update happens on the first rising clk edge after rst goes high.
- Latency: 1 cycle. final at edge N+1 reflects a, b and select sampled at edge N; it holds between edges.
- Inputs that are X/unknown before the first valid stimulus may produce X in final. This is not checked.
- All arithmetic is unsigned and modulo 2^WIDTH. There are no carry, overflow or flag outputs.
- Opcodes:
  - 0000 ADD: a + b, carry discarded.
  - 0001 SUB: a - b, borrow discarded (wraps).
  - 0010 AND: a & b.
  - 0011 OR: a | b.
  - 0100 XOR: a ^ b.
  - 0101 NOT: ~a (b ignored).
  - 0110 SHL: a << 1, zero fill.
  - 0111 SHR: a >> 1 (logical), zero fill.
  - 1000 ROL: rotate a left by 1; MSB goes to LSB.
  - 1001 ROR: rotate a right by 1; LSB goes to MSB.
  - 1010 MUL: low WIDTH bits of a * b.
  - 1011 INC: a + 1 (wraps FF -> 00).
  - 1100 DEC: a - 1 (wraps 00 -> FF).
  - 1101 EQ: 1 if a == b, else 0 (zero-extended).
  - 1110 LTU: 1 if a < b unsigned, else 0.
  - 1111 PASSB: b.
- A change of select, a or b between edges has no effect until the next edge.
- Reset asserted mid-operation clears final at once; the pending result is lost.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit opcode enum, names as listed in Behaviour;
  - the WIDTH default constant.
- Sub-module alu_ops: purely combinational (a, b, select) -> result.
- alu_core: alu_ops plus the output register with async active-low reset.

Test Plan:
- Reset: hold rst low for 2 cycles with random a/b -> final = 00 throughout; release -> first edge loads the computed result.
- Add wrap: a=55, b=B5, ADD -> final=0A one cycle later.
- Logic and subtract: a=DB, b=AA.
  - SUB -> 31
  - AND -> 8A
  - OR -> FB
  - XOR -> 71
- Unary and shifts: a=17, NOT -> E8. Then a=97, b=AA:
  - SHL -> 2E
  - SHR -> 4B
  - ROL -> 2F
  - ROR -> CB
  - MUL -> 46
- Boundaries:
  - INC a=FF -> 00
  - DEC a=00 -> FF
  - EQ a=b=3C -> 01
  - LTU a=01, b=FF -> 01
  - PASSB b=5A -> 5A
- Mid-cycle change and async reset: change select between edges -> final unchanged until the next edge; pulse rst low between edges -> final=00 immediately, without waiting for a clock.
